ts_frame_bram_writer: RTL and testbench

- Timestamps ADC sample frames arriving on AXI-Stream and writes them into a ping-pong BRAM as a header plus channel words.
- Header is the PPS-disciplined seconds/nanoseconds time.
- Raises an interrupt once a complete frame sits in the finished bank.
- Sits between the ADC frame sequencer and the AXI BRAM controller read by the PS driver.

---
 rtl/ts_frame_bram_writer_pkg.sv | 19 +
 rtl/ts_frame_bram_writer_if.sv | 13 +
 rtl/ts_frame_bram_writer_ptp_sec_ns_counter.sv | 55 +++++
 rtl/ts_frame_bram_writer.sv | 230 +++++++++++++++++++++++
 tb/tb_ts_frame_bram_writer.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ts_frame_bram_writer_pkg.sv
// ts_frame_pkg: shared constants, header-size helper and FSM state type for
// the timestamped frame BRAM writer.
package ts_frame_pkg;

    localparam int NS_PER_SEC  = 1_000_000_000;
    localparam int HALF_SEC_NS = 500_000_000;

    // Header carries 32-bit seconds + 32-bit nanoseconds, split into BRAM words.
    function automatic int hdr_words(input int data_w);
        return 64 / data_w;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA
    } state_t;

endpackage

// File: rtl/ts_frame_bram_writer_if.sv
// ts_frame_axis_if: AXI-Stream beat channel (tdata/tvalid/tready).
//   master: drives tdata, tvalid; receives tready.
//   slave : receives tdata, tvalid; drives tready.
interface ts_frame_axis_if #(
    parameter int TDATA_W = 56
) ();
    logic [TDATA_W-1:0] tdata;
    logic               tvalid;
    logic               tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/ts_frame_bram_writer_ptp_sec_ns_counter.sv
// ptp_sec_ns_counter: free-running seconds/nanoseconds clock disciplined by PPS.
//   aclk, aresetn : clock, synchronous active-low reset
//   i_pps         : PPS, already synchronous to aclk; rising edge zeroes ns
//   o_sec, o_ns   : current time
module ptp_sec_ns_counter
    import ts_frame_pkg::*;
#(
    parameter int CLK_PERIOD_NS = 8
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        i_pps,
    output logic [31:0] o_sec,
    output logic [31:0] o_ns
);
    localparam logic [31:0] NS_STEP = 32'(CLK_PERIOD_NS);
    localparam logic [31:0] NS_LAST = 32'(NS_PER_SEC - CLK_PERIOD_NS);
    localparam logic [31:0] NS_HALF = 32'(HALF_SEC_NS);

    if (CLK_PERIOD_NS < 1 || (NS_PER_SEC % CLK_PERIOD_NS) != 0) begin : g_bad_period
        $error("CLK_PERIOD_NS must divide 10**9");
    end

    logic        r_pps_d;
    logic [31:0] r_sec;
    logic [31:0] r_ns;
    logic        w_pps_rise;

    assign w_pps_rise = i_pps & ~r_pps_d;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_pps_d <= 1'b0;
            r_sec   <= '0;
            r_ns    <= '0;
        end else begin
            r_pps_d <= i_pps;
            if (w_pps_rise) begin
                // Late half of the second: PPS stands in for the wrap we are
                // about to do (or are doing this cycle), so count it once.
                r_ns <= '0;
                if (r_ns >= NS_HALF) r_sec <= r_sec + 32'd1;
            end else if (r_ns == NS_LAST) begin
                r_ns  <= '0;
                r_sec <= r_sec + 32'd1;
            end else begin
                r_ns <= r_ns + NS_STEP;
            end
        end
    end

    assign o_sec = r_sec;
    assign o_ns  = r_ns;

endmodule

// File: rtl/ts_frame_bram_writer.sv
// ts_frame_bram_writer: timestamps ADC frames from AXI-Stream into a ping-pong
// BRAM (header = sec/ns, then one word per channel) and interrupts when a
// complete frame is in the finished bank.
//   aclk, aresetn         : clock, synchronous active-low reset
//   s_axis                : beat input; tdata = {.., code[7:0], sample[DATA_W-1:0]}
//   pps                   : synchronised PPS
//   bram_*                : write-only BRAM port, address = {bank, offset}
//   ts_irq                : frame-ready interrupt, IRQ_CYCLES long
//   done_bank             : bank holding the latest complete frame
//   frame_err             : one-cycle pulse on frame abandon/restart
//   frame_cnt             : completed frame count (wraps)
module ts_frame_bram_writer
    import ts_frame_pkg::*;
#(
    parameter int          CHANNELS      = 32,
    parameter int          DATA_W        = 16,
    parameter int          TDATA_W       = 56,
    parameter logic [7:0]  TS_CODE       = 8'h3F,
    parameter int          CLK_PERIOD_NS = 8,
    parameter int          ADDR_W        = 12,
    parameter int          IRQ_CYCLES    = 256
) (
    input  logic                aclk,
    input  logic                aresetn,
    ts_frame_axis_if.slave      s_axis,
    input  logic                pps,
    output logic                bram_clk,
    output logic                bram_rst,
    output logic [ADDR_W-1:0]   bram_addr,
    output logic                bram_en,
    output logic [DATA_W-1:0]   bram_din,
    input  logic [DATA_W-1:0]   bram_dout,
    output logic [DATA_W/8-1:0] bram_we,
    output logic                ts_irq,
    output logic                done_bank,
    output logic                frame_err,
    output logic [15:0]         frame_cnt
);
    localparam int HDR_WORDS  = hdr_words(DATA_W);
    localparam int BANK_WORDS = 2 ** (ADDR_W - 1);
    localparam int OFF_W      = ADDR_W - 1;
    localparam int HCNT_W     = (HDR_WORDS > 2) ? 2 : 1;
    localparam int WE_W       = DATA_W / 8;
    localparam int IRQ_W      = $clog2(IRQ_CYCLES + 1);

    if (DATA_W != 16 && DATA_W != 32) begin : g_bad_dw
        $error("DATA_W must be 16 or 32");
    end
    if (TDATA_W < DATA_W + 8) begin : g_bad_tdw
        $error("TDATA_W must be >= DATA_W+8");
    end
    if (CHANNELS < 1 || CHANNELS > 255 || int'(TS_CODE) < CHANNELS) begin : g_bad_ch
        $error("CHANNELS must be 1..255 and <= TS_CODE");
    end
    if (HDR_WORDS + CHANNELS > BANK_WORDS) begin : g_bad_bank
        $error("frame does not fit in one BRAM bank");
    end
    if (IRQ_CYCLES < 1) begin : g_bad_irq
        $error("IRQ_CYCLES must be >= 1");
    end

    // Time base
    logic [31:0] w_sec;
    logic [31:0] w_ns;

    ptp_sec_ns_counter #(.CLK_PERIOD_NS(CLK_PERIOD_NS)) u_time (
        .aclk    (aclk),
        .aresetn (aresetn),
        .i_pps   (pps),
        .o_sec   (w_sec),
        .o_ns    (w_ns)
    );

    // State and datapath registers
    state_t              r_state;
    state_t              w_next;
    logic                r_run;       // holds tready low for the first cycle out of reset
    logic [HCNT_W-1:0]   r_hcnt;
    logic [7:0]          r_exp;
    logic                r_bank;
    logic [31:0]         r_hdr_sec;
    logic [31:0]         r_hdr_ns;
    logic                r_bram_en;
    logic [WE_W-1:0]     r_bram_we;
    logic [ADDR_W-1:0]   r_bram_addr;
    logic [DATA_W-1:0]   r_bram_din;
    logic                r_frame_err;
    logic                r_done_bank;
    logic [15:0]         r_frame_cnt;
    logic                r_irq_start;
    logic [IRQ_W-1:0]    r_irq_cnt;

    logic                w_tready;
    logic                w_acc;
    logic [7:0]          w_code;
    logic [DATA_W-1:0]   w_sample;
    logic [63:0]         w_hdr64;
    logic [DATA_W-1:0]   w_hdr_word;
    logic                w_wr;
    logic [OFF_W-1:0]    w_off;
    logic [DATA_W-1:0]   w_wdata;
    logic                w_latch;
    logic                w_err;
    logic                w_done;
    logic                w_unused;

    assign w_tready = r_run && (r_state != ST_HDR);
    assign w_acc    = s_axis.tvalid && w_tready;
    assign w_code   = s_axis.tdata[DATA_W+7:DATA_W];
    assign w_sample = s_axis.tdata[DATA_W-1:0];
    assign w_unused = ^{bram_dout, s_axis.tdata};

    // Header word k is taken MSB-first from {sec, ns}.
    assign w_hdr64    = {r_hdr_sec, r_hdr_ns};
    assign w_hdr_word = DATA_W'(w_hdr64 >> (DATA_W * (HDR_WORDS - 1 - int'(r_hcnt))));

    always_ff @(posedge aclk) begin
        if (!aresetn) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_wr    = 1'b0;
        w_off   = '0;
        w_wdata = '0;
        w_latch = 1'b0;
        w_err   = 1'b0;
        w_done  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_acc && w_code == TS_CODE) begin
                    w_latch = 1'b1;
                    w_next  = ST_HDR;
                end
            end
            ST_HDR: begin
                w_wr    = 1'b1;
                w_off   = OFF_W'(r_hcnt);
                w_wdata = w_hdr_word;
                if (r_hcnt == HCNT_W'(HDR_WORDS - 1)) w_next = ST_DATA;
            end
            ST_DATA: begin
                if (w_acc) begin
                    if (w_code == TS_CODE) begin
                        // New marker mid-frame: restart in the same bank.
                        w_err   = 1'b1;
                        w_latch = 1'b1;
                        w_next  = ST_HDR;
                    end else if (w_code == r_exp) begin
                        w_wr    = 1'b1;
                        w_off   = OFF_W'(HDR_WORDS) + OFF_W'(r_exp);
                        w_wdata = w_sample;
                        if (r_exp == 8'(CHANNELS - 1)) begin
                            w_done = 1'b1;
                            w_next = ST_IDLE;
                        end
                    end else begin
                        w_err  = 1'b1;
                        w_next = ST_IDLE;
                    end
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_run       <= 1'b0;
            r_hcnt      <= '0;
            r_exp       <= '0;
            r_bank      <= 1'b0;
            r_hdr_sec   <= '0;
            r_hdr_ns    <= '0;
            r_bram_en   <= 1'b0;
            r_bram_we   <= '0;
            r_bram_addr <= '0;
            r_bram_din  <= '0;
            r_frame_err <= 1'b0;
            r_done_bank <= 1'b0;
            r_frame_cnt <= '0;
            r_irq_start <= 1'b0;
            r_irq_cnt   <= '0;
        end else begin
            r_run       <= 1'b1;
            r_bram_en   <= w_wr;
            r_bram_we   <= {WE_W{w_wr}};
            r_bram_addr <= w_wr ? {r_bank, w_off} : '0;
            r_bram_din  <= w_wr ? w_wdata : '0;
            r_frame_err <= w_err;

            // Timestamp of the marker's own cycle, not of the first header write.
            if (w_latch) begin
                r_hdr_sec <= w_sec;
                r_hdr_ns  <= w_ns;
                r_hcnt    <= '0;
            end else if (r_state == ST_HDR) begin
                r_hcnt <= r_hcnt + 1'b1;  // HDR_WORDS is 2**HCNT_W, so it wraps to 0
            end

            if (r_state == ST_HDR) r_exp <= '0;
            else if (w_wr)         r_exp <= r_exp + 8'd1;

            if (w_done) begin
                r_done_bank <= r_bank;
                r_bank      <= ~r_bank;
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end

            // One-cycle delay so the IRQ rises after the last write is visible.
            r_irq_start <= w_done;
            if (r_irq_start)           r_irq_cnt <= IRQ_W'(IRQ_CYCLES);
            else if (r_irq_cnt != '0)  r_irq_cnt <= r_irq_cnt - 1'b1;
        end
    end

    assign s_axis.tready = w_tready;
    assign bram_clk      = aclk;
    assign bram_rst      = !aresetn;
    assign bram_addr     = r_bram_addr;
    assign bram_en       = r_bram_en;
    assign bram_din      = r_bram_din;
    assign bram_we       = r_bram_we;
    assign ts_irq        = (r_irq_cnt != '0);
    assign done_bank     = r_done_bank;
    assign frame_err     = r_frame_err;
    assign frame_cnt     = r_frame_cnt;

endmodule

// File: tb/tb_ts_frame_bram_writer.sv
// Directed bench: default instance (DATA_W=16, 32 ch) and wide instance
// (DATA_W=32, 8 ch, ADDR_W=6, 16 cycles per simulated second).
module tb_ts_frame_bram_writer;
    localparam logic [7:0] TS = 8'h3F;

    logic aclk = 1'b0;
    always #5 aclk = ~aclk;

    logic rstn_a, rstn_b, pps_a, pps_b;

    ts_frame_axis_if #(.TDATA_W(56)) ax_a ();
    ts_frame_axis_if #(.TDATA_W(56)) ax_b ();

    logic        bclk_a, brst_a, en_a, irq_a_o, dbank_a, ferr_a;
    logic [11:0] addr_a;
    logic [15:0] din_a, dout_a;
    logic [1:0]  we_a;
    logic [15:0] fcnt_a;

    logic        bclk_b, brst_b, en_b, irq_b_o, dbank_b, ferr_b;
    logic [5:0]  addr_b;
    logic [31:0] din_b, dout_b;
    logic [3:0]  we_b;
    logic [15:0] fcnt_b;

    assign dout_a = '0;
    assign dout_b = '0;

    ts_frame_bram_writer u_dut_a (
        .aclk(aclk), .aresetn(rstn_a), .s_axis(ax_a), .pps(pps_a),
        .bram_clk(bclk_a), .bram_rst(brst_a), .bram_addr(addr_a), .bram_en(en_a),
        .bram_din(din_a), .bram_dout(dout_a), .bram_we(we_a), .ts_irq(irq_a_o),
        .done_bank(dbank_a), .frame_err(ferr_a), .frame_cnt(fcnt_a)
    );

    ts_frame_bram_writer #(
        .CHANNELS(8), .DATA_W(32), .TDATA_W(56), .ADDR_W(6),
        .CLK_PERIOD_NS(62_500_000), .IRQ_CYCLES(16)
    ) u_dut_b (
        .aclk(aclk), .aresetn(rstn_b), .s_axis(ax_b), .pps(pps_b),
        .bram_clk(bclk_b), .bram_rst(brst_b), .bram_addr(addr_b), .bram_en(en_b),
        .bram_din(din_b), .bram_dout(dout_b), .bram_we(we_b), .ts_irq(irq_b_o),
        .done_bank(dbank_b), .frame_err(ferr_b), .frame_cnt(fcnt_b)
    );

    // BRAM models and event counters, sampled on the falling edge
    logic [15:0] mem_a [0:4095];
    logic [31:0] mem_b [0:63];
    int wr_a = 0, irq_a = 0, err_a = 0;

    always @(negedge aclk) begin
        if (en_a) begin mem_a[addr_a] = din_a; wr_a++; end
        if (en_b) mem_b[addr_b] = din_b;
        if (irq_a_o) irq_a++;
        if (ferr_a) err_a++;
    end

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge aclk);
    endtask

    // Present a beat at a falling edge, hold until accepted, return at the
    // falling edge right after the accepting rising edge.
    task automatic beat_a(input logic [7:0] code, input logic [15:0] s);
        int n = 0;
        ax_a.tdata  = {32'h0, code, s};
        ax_a.tvalid = 1'b1;
        while (!ax_a.tready && n < 50) begin @(negedge aclk); n++; end
        if (n >= 50) chk("beat_a_timeout", 64'(n), 64'd0);
        @(negedge aclk);
        ax_a.tvalid = 1'b0;
    endtask

    task automatic beat_b(input logic [7:0] code, input logic [31:0] s);
        int n = 0;
        ax_b.tdata  = {16'h0, code, s};
        ax_b.tvalid = 1'b1;
        while (!ax_b.tready && n < 50) begin @(negedge aclk); n++; end
        if (n >= 50) chk("beat_b_timeout", 64'(n), 64'd0);
        @(negedge aclk);
        ax_b.tvalid = 1'b0;
    endtask

    task automatic frame_a(input logic [15:0] base);
        beat_a(TS, 16'h0);
        for (int c = 0; c < 32; c++) beat_a(8'(c), base + 16'(c));
    endtask

    task automatic frame_b(input logic [31:0] base);
        beat_b(TS, 32'h0);
        for (int c = 0; c < 8; c++) beat_b(8'(c), base + 32'(c));
    endtask

    int s0, s1;

    initial begin
        for (int i = 0; i < 4096; i++) mem_a[i] = 16'hDEAD;
        for (int i = 0; i < 64; i++)   mem_b[i] = 32'hDEADBEEF;
        rstn_a = 1'b0; rstn_b = 1'b0; pps_a = 1'b0; pps_b = 1'b0;
        ax_a.tvalid = 1'b0; ax_a.tdata = '0;
        ax_b.tvalid = 1'b0; ax_b.tdata = '0;
        tick(3);

        // Reset state
        chk("rst_tready", ax_a.tready, 0);
        chk("rst_en", en_a, 0);
        chk("rst_irq", irq_a_o, 0);
        chk("rst_fcnt", fcnt_a, 0);
        chk("rst_dbank", dbank_a, 0);
        chk("rst_bram_rst", brst_a, 1);
        rstn_a = 1'b1;                      // rising edge 1 follows
        tick(1);
        chk("tready_up", ax_a.tready, 1);
        chk("bram_rst_rel", brst_a, 0);

        // PPS sampled at edge 26 while ns=200: ns->0, sec stays 0.
        // Marker accepted at edge 30 latches ns=24.
        tick(24); pps_a = 1'b1;
        tick(4);  pps_a = 1'b0;
        beat_a(TS, 16'h0);
        for (int i = 0; i < 4; i++) begin
            chk("hdr_tready_low", ax_a.tready, 0);
            tick(1);
        end
        chk("hdr_tready_back", ax_a.tready, 1);
        for (int c = 0; c < 32; c++) begin
            beat_a(8'(c), 16'h1000 + 16'(c));
            if (c == 0) begin
                chk("ch0_en", en_a, 1);
                chk("ch0_we", we_a, 2'b11);
                chk("ch0_addr", addr_a, 12'd4);
                chk("ch0_din", din_a, 16'h1000);
            end
        end
        chk("last_addr", addr_a, 12'd35);
        chk("irq_not_yet", irq_a_o, 0);
        chk("f1_cnt", fcnt_a, 1);
        s0 = irq_a;
        tick(1);
        chk("irq_rise", irq_a_o, 1);
        tick(300);
        chk("irq_len", 64'(irq_a - s0), 64'd256);
        chk("f1_hdr0", mem_a[0], 16'h0);
        chk("f1_hdr1", mem_a[1], 16'h0);
        chk("f1_hdr2", mem_a[2], 16'h0);
        chk("f1_hdr3", mem_a[3], 16'd24);
        chk("f1_s0", mem_a[4], 16'h1000);
        chk("f1_s31", mem_a[35], 16'h101F);
        chk("f1_writes", 64'(wr_a), 64'd36);
        chk("f1_dbank", dbank_a, 0);

        // Ping-pong
        s0 = wr_a;
        frame_a(16'h2000);
        tick(5);
        chk("f2_hdr0", mem_a[12'h800], 16'h0);
        chk("f2_s0", mem_a[12'h804], 16'h2000);
        chk("f2_s31", mem_a[12'h823], 16'h201F);
        chk("f2_writes", 64'(wr_a - s0), 64'd36);
        chk("f2_dbank", dbank_a, 1);
        chk("f2_cnt", fcnt_a, 2);
        frame_a(16'h3000);
        tick(300);
        chk("f3_s0", mem_a[4], 16'h3000);
        chk("f3_dbank", dbank_a, 0);
        chk("f3_cnt", fcnt_a, 3);

        // Abandoned frame: 0,1,3 in bank 1
        s0 = err_a; s1 = irq_a;
        beat_a(TS, 16'h0);
        beat_a(8'd0, 16'h4000);
        beat_a(8'd1, 16'h4001);
        beat_a(8'd3, 16'h4003);
        chk("ab_err_pulse", ferr_a, 1);
        tick(10);
        chk("ab_err_len", 64'(err_a - s0), 64'd1);
        chk("ab_no_irq", 64'(irq_a - s1), 64'd0);
        chk("ab_cnt", fcnt_a, 3);
        chk("ab_dbank", dbank_a, 0);
        chk("ab_s0", mem_a[12'h804], 16'h4000);
        chk("ab_s3_unwritten", mem_a[12'h807], 16'h2003);
        frame_a(16'h5000);
        tick(5);
        chk("f5_same_bank", mem_a[12'h804], 16'h5000);
        chk("f5_dbank", dbank_a, 1);
        chk("f5_cnt", fcnt_a, 4);

        // Reset mid-frame: partial frame in bank 1, reset lands on channel 10
        frame_a(16'h6000);
        beat_a(TS, 16'h0);
        for (int c = 0; c < 10; c++) beat_a(8'(c), 16'h8000 + 16'(c));
        ax_a.tdata = {32'h0, 8'd10, 16'h800A};
        ax_a.tvalid = 1'b1;
        rstn_a = 1'b0;
        tick(1);
        ax_a.tvalid = 1'b0;
        chk("mr_cnt", fcnt_a, 0);
        chk("mr_dbank", dbank_a, 0);
        chk("mr_irq", irq_a_o, 0);
        chk("mr_en", en_a, 0);
        chk("mr_tready", ax_a.tready, 0);
        s1 = irq_a;
        rstn_a = 1'b1;
        tick(3);
        chk("mr_no_irq", 64'(irq_a - s1), 64'd0);
        chk("mr_partial_b1", mem_a[12'h804], 16'h8000);
        frame_a(16'h7000);
        tick(5);
        chk("mr_next_b0", mem_a[4], 16'h7000);
        chk("mr_next_s31", mem_a[35], 16'h701F);
        chk("mr_next_cnt", fcnt_a, 1);
        chk("mr_next_dbank", dbank_a, 0);

        // Wide: PPS at edge 16 coincides with the natural wrap -> sec=1 once
        rstn_b = 1'b1;
        tick(15); pps_b = 1'b1;
        tick(1);  pps_b = 1'b0;
        beat_b(TS, 32'h0);
        for (int c = 0; c < 8; c++) begin
            beat_b(8'(c), 32'hC0DE_0000 + 32'(c));
            if (c == 0) begin
                chk("w_we", we_b, 4'b1111);
                chk("w_ch0_addr", addr_b, 6'd2);
            end
        end
        tick(5);
        chk("w_hdr_sec", mem_b[0], 32'd1);
        chk("w_hdr_ns", mem_b[1], 32'd0);
        chk("w_s0", mem_b[2], 32'hC0DE_0000);
        chk("w_s7", mem_b[9], 32'hC0DE_0007);
        chk("w_cnt", fcnt_b, 1);

        // Wide: early PPS at edge 10 (ns=562.5M) -> sec=1; marker at edge 12
        rstn_b = 1'b0;
        tick(2);
        rstn_b = 1'b1;
        tick(9);  pps_b = 1'b1;
        tick(1);  pps_b = 1'b0;
        tick(1);
        frame_b(32'hA5A5_0000);
        frame_b(32'hBEEF_0000);
        tick(5);
        chk("w2_hdr_sec", mem_b[0], 32'd1);
        chk("w2_hdr_ns", mem_b[1], 32'd62_500_000);
        chk("w2_s0", mem_b[2], 32'hA5A5_0000);
        chk("w2_b1_s0", mem_b[34], 32'hBEEF_0000);
        chk("w2_b1_s7", mem_b[41], 32'hBEEF_0007);
        chk("w2_dbank", dbank_b, 1);
        chk("w2_cnt", fcnt_b, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
